// File: rtl/instr_mem_loadable.sv
// IF-stage instruction memory: registered fetch with stall/flush/range check,
// plus a byte-serial load port that packs big-endian words into program memory.
module instr_mem_loadable #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 512,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  HALT_WORD  = 32'hFFFFFFFF,
    parameter logic [DATA_WIDTH-1:0]  NOP_WORD   = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      i_pc,
    input  logic                       i_stall,
    input  logic                       i_flush,
    output logic [DATA_WIDTH-1:0]      o_instruction,
    output logic                       o_valid,
    output logic                       o_addr_err,
    input  logic                       i_load_en,
    input  logic                       i_byte_valid,
    input  logic [7:0]                 i_byte,
    output logic                       o_loading,
    output logic                       o_load_done,
    output logic [$clog2(DEPTH):0]     o_word_count,
    output logic                       o_overflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned BC_W  = $clog2(BPW) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0]   asm_word;
    logic [BC_W-1:0]         byte_cnt;
    logic [CNT_W-1:0]        wr_ptr;

    logic                    mem_full;
    logic                    take_byte;
    logic                    word_done;
    logic                    wr_en;
    logic [DATA_WIDTH+7:0]   shifted;
    logic [DATA_WIDTH-1:0]   next_word;
    logic [IDX_W-1:0]        rd_idx;
    logic                    pc_bad;

    always_comb begin
        mem_full  = (wr_ptr == CNT_W'(DEPTH));
        take_byte = (state == LOAD) && i_byte_valid && !mem_full;
        // Shifting through a wider temporary keeps the packing valid for any BPW.
        shifted   = {asm_word, i_byte};
        next_word = shifted[DATA_WIDTH-1:0];
        word_done = take_byte && (byte_cnt == BC_W'(BPW - 1));
        wr_en     = word_done && !reset;
        rd_idx    = i_pc[IDX_W+1:2];
        pc_bad    = (i_pc[1:0] != 2'b00) || (|i_pc[ADDR_WIDTH-1:IDX_W+2]);
    end

    // Program memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[IDX_W-1:0]] <= next_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            asm_word      <= '0;
            byte_cnt      <= '0;
            wr_ptr        <= '0;
            o_instruction <= NOP_WORD;
            o_valid       <= 1'b0;
            o_addr_err    <= 1'b0;
            o_load_done   <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_load_done <= 1'b0;
            case (state)
                LOAD: begin
                    o_instruction <= NOP_WORD;
                    o_valid       <= 1'b0;
                    o_addr_err    <= 1'b0;
                    if (i_byte_valid && mem_full)
                        o_overflow <= 1'b1;
                    if (take_byte) begin
                        asm_word <= next_word;
                        if (word_done) begin
                            byte_cnt <= '0;
                            wr_ptr   <= wr_ptr + 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                    // Exit drops any partial word; a final byte on the same edge still counts.
                    if (!i_load_en || (word_done && next_word == HALT_WORD)) begin
                        state       <= RUN;
                        o_load_done <= 1'b1;
                        byte_cnt    <= '0;
                    end
                end
                default: begin
                    if (i_flush) begin
                        o_instruction <= NOP_WORD;
                        o_valid       <= 1'b0;
                        o_addr_err    <= 1'b0;
                    end else if (!i_stall) begin
                        if (pc_bad) begin
                            o_instruction <= NOP_WORD;
                            o_valid       <= 1'b0;
                            o_addr_err    <= 1'b1;
                        end else begin
                            o_instruction <= mem[rd_idx];
                            o_valid       <= 1'b1;
                            o_addr_err    <= 1'b0;
                        end
                    end
                    if (i_load_en) begin
                        state      <= LOAD;
                        wr_ptr     <= '0;
                        byte_cnt   <= '0;
                        o_overflow <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_loading    = (state == LOAD);
    assign o_word_count = wr_ptr;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: a 512-word and a 4-word instance share stimulus,
// each checked every cycle against its own behavioural model.
module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        load_en = 1'b0, bv = 1'b0;
    logic [7:0]  bdata = '0;

    logic [31:0] ins_b, ins_s;
    logic        val_b, val_s, err_b, err_s, ld_b, ld_s, dn_b, dn_s, ov_b, ov_s;
    logic [9:0]  cnt_b;
    logic [2:0]  cnt_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_mem_loadable u_big (
        .clk(clk), .reset(reset), .i_pc(pc), .i_stall(stall), .i_flush(flush),
        .o_instruction(ins_b), .o_valid(val_b), .o_addr_err(err_b),
        .i_load_en(load_en), .i_byte_valid(bv), .i_byte(bdata),
        .o_loading(ld_b), .o_load_done(dn_b), .o_word_count(cnt_b), .o_overflow(ov_b)
    );

    instr_mem_loadable #(.DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .i_pc(pc), .i_stall(stall), .i_flush(flush),
        .o_instruction(ins_s), .o_valid(val_s), .o_addr_err(err_s),
        .i_load_en(load_en), .i_byte_valid(bv), .i_byte(bdata),
        .o_loading(ld_s), .o_load_done(dn_s), .o_word_count(cnt_s), .o_overflow(ov_s)
    );

    // Reference model, index 0 = 512 words, index 1 = 4 words.
    int unsigned dep [2] = '{512, 4};
    logic [31:0] m_mem [2][512];
    bit          m_loading [2];
    int unsigned m_nbytes [2];
    logic [31:0] m_acc [2];
    logic [31:0] e_ins [2];
    bit          e_val [2], e_err [2], e_done [2], e_ovf [2];
    int unsigned e_cnt [2];

    task automatic model_update(input int k);
        bit halt;
        if (reset) begin
            m_loading[k] = 0; m_nbytes[k] = 0; m_acc[k] = 0;
            e_ins[k] = 0; e_val[k] = 0; e_err[k] = 0;
            e_done[k] = 0; e_cnt[k] = 0; e_ovf[k] = 0;
        end else if (m_loading[k]) begin
            halt = 0;
            e_done[k] = 0;
            e_ins[k] = 0; e_val[k] = 0; e_err[k] = 0;
            if (bv) begin
                if (e_cnt[k] == dep[k]) begin
                    e_ovf[k] = 1;
                end else begin
                    m_acc[k] = m_acc[k] * 256 + 32'(bdata);
                    m_nbytes[k]++;
                    if (m_nbytes[k] == 4) begin
                        m_mem[k][e_cnt[k]] = m_acc[k];
                        halt = (m_acc[k] == 32'hFFFFFFFF);
                        e_cnt[k]++;
                        m_nbytes[k] = 0; m_acc[k] = 0;
                    end
                end
            end
            if (!load_en || halt) begin
                m_loading[k] = 0; e_done[k] = 1;
                m_nbytes[k] = 0; m_acc[k] = 0;
            end
        end else begin
            e_done[k] = 0;
            if (flush) begin
                e_ins[k] = 0; e_val[k] = 0; e_err[k] = 0;
            end else if (!stall) begin
                if (pc % 4 != 0 || pc >= dep[k] * 4) begin
                    e_ins[k] = 0; e_val[k] = 0; e_err[k] = 1;
                end else begin
                    e_ins[k] = m_mem[k][pc / 4]; e_val[k] = 1; e_err[k] = 0;
                end
            end
            if (load_en) begin
                m_loading[k] = 1; e_cnt[k] = 0; e_ovf[k] = 0;
                m_nbytes[k] = 0; m_acc[k] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("instruction_%0d", k), (k == 0) ? 64'(ins_b) : 64'(ins_s), 64'(e_ins[k]));
            chk($sformatf("valid_%0d", k),       (k == 0) ? 64'(val_b) : 64'(val_s), 64'(e_val[k]));
            chk($sformatf("addr_err_%0d", k),    (k == 0) ? 64'(err_b) : 64'(err_s), 64'(e_err[k]));
            chk($sformatf("loading_%0d", k),     (k == 0) ? 64'(ld_b)  : 64'(ld_s),  64'(m_loading[k]));
            chk($sformatf("load_done_%0d", k),   (k == 0) ? 64'(dn_b)  : 64'(dn_s),  64'(e_done[k]));
            chk($sformatf("word_count_%0d", k),  (k == 0) ? 64'(cnt_b) : 64'(cnt_s), 64'(e_cnt[k]));
            chk($sformatf("overflow_%0d", k),    (k == 0) ? 64'(ov_b)  : 64'(ov_s),  64'(e_ovf[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bv = 1'b1; bdata = b;
        step();
        bv = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    endtask

    logic [31:0] prog [3] = '{32'h02538820, 32'h00A62020, 32'hFFFFFFFF};
    logic [31:0] w5 [5];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 512; i++) m_mem[k][i] = '0;

        // Reset
        reset = 1'b1; step(); step();
        chk("reset_instruction", 64'(ins_b), 64'h0);
        reset = 1'b0;

        // Test 1: load three words ending with HALT
        load_en = 1'b1; step();
        for (int i = 0; i < 3; i++) send_word(prog[i]);
        chk("t1_done_pulse", 64'(dn_b), 64'h1);
        chk("t1_count", 64'(cnt_b), 64'd3);
        load_en = 1'b0; step();
        chk("t1_done_single", 64'(dn_b), 64'h0);

        // Test 2: fetch back-to-back
        pc = 32'd0; step(); chk("t2_pc0", 64'(ins_b), 64'h02538820);
        pc = 32'd4; step(); chk("t2_pc4", 64'(ins_b), 64'h00A62020);
        pc = 32'd8; step(); chk("t2_pc8", 64'(ins_b), 64'hFFFFFFFF);
        chk("t2_valid", 64'(val_b), 64'h1);

        // Test 3: stall holds, flush wins over stall
        pc = 32'd4; stall = 1'b1;
        repeat (3) step();
        chk("t3_hold", 64'(ins_b), 64'hFFFFFFFF);
        flush = 1'b1; step();
        chk("t3_flush", 64'(ins_b), 64'h0);
        chk("t3_flush_valid", 64'(val_b), 64'h0);
        flush = 1'b0; stall = 1'b0;

        // Test 4: address errors and the last in-range word
        pc = 32'h802; step(); chk("t4_misaligned", 64'(err_b), 64'h1);
        pc = 32'h800; step(); chk("t4_out_of_range", 64'(err_b), 64'h1);
        pc = 32'h7FC; step(); chk("t4_last_word_err", 64'(err_b), 64'h0);
        chk("t4_last_word_valid", 64'(val_b), 64'h1);

        // Test 5: overflow on the 4-word instance
        load_en = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            w5[i] = $urandom & 32'h7FFFFFFF;
            send_word(w5[i]);
        end
        chk("t5_small_count", 64'(cnt_s), 64'd4);
        chk("t5_small_overflow", 64'(ov_s), 64'h1);
        chk("t5_big_count", 64'(cnt_b), 64'd5);
        load_en = 1'b0; step();
        chk("t5_done", 64'(dn_s), 64'h1);
        pc = 32'd12; step();
        chk("t5_small_mem3", 64'(ins_s), 64'(w5[3]));

        // Test 6: partial word discarded, then reset mid-byte
        load_en = 1'b1; step();
        send_word(32'h11223344);
        send_byte(8'hAA); send_byte(8'hBB);
        load_en = 1'b0; step();
        chk("t6_count", 64'(cnt_b), 64'd1);
        pc = 32'd4; step();
        chk("t6_mem1_kept", 64'(ins_b), 64'(w5[1]));
        load_en = 1'b1; step();
        send_word(32'h55667788);
        send_byte(8'hAA);
        reset = 1'b1; bv = 1'b1; bdata = 8'hBB; step();
        reset = 1'b0; bv = 1'b0; load_en = 1'b0;
        chk("t6_reset_loading", 64'(ld_b), 64'h0);
        pc = 32'd0; step();
        chk("t6_mem0_kept", 64'(ins_b), 64'h55667788);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) load_en = ~load_en;
            bv    = ($urandom_range(0, 1) == 1);
            bdata = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 5))
                0:       pc = $urandom_range(0, 2100);
                1:       pc = $urandom;
                2:       pc = 32'($urandom_range(0, 3)) << 2;
                default: pc = 32'($urandom_range(0, 520)) << 2;
            endcase
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
